hiscore_ram_port: RTL
=====================

HISCORE_RAM_PORT -- requirements
Module: hiscore_ram_port

Interface
REQ-001 Parameter BASE, default 16'hC000: first hiscore-visible address of Z80 work RAM.
REQ-002 Parameter AW, default 12: work-RAM address width; the window is BASE .. BASE+2^AW-1.
REQ-003 Parameter GUARD, default 4: number of consecutive CPU-idle cycles required before the hiscore engine is granted the RAM.
REQ-004 clk48M  in  1  sole clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 cpu_ad  in  16  Z80 address.
REQ-007 cpu_do  in  8  Z80 write data.
REQ-008 cpu_mreq  in  1  Z80 memory cycle active for the RAM window.
REQ-009 cpu_wr  in  1  Z80 write strobe, qualified by cpu_mreq.
REQ-010 hs_access  in  1  hiscore engine requests RAM ownership (level).
REQ-011 hs_ad  in  16  hiscore address.
REQ-012 hs_di  in  8  hiscore write data.
REQ-013 hs_we  in  1  hiscore write strobe, one cycle per byte.
REQ-014 ram_rd  in  8  work-RAM read data; 1-cycle BRAM latency.
REQ-015 ram_ad  out  AW  work-RAM address.
REQ-016 ram_wd  out  8  work-RAM write data.
REQ-017 ram_we  out  1  work-RAM write enable.
REQ-018 hs_do  out  8  registered read data to the hiscore engine.
REQ-019 hs_grant  out  1  hiscore engine owns the RAM.
REQ-020 cpu_pause  out  1  stall request to the core; drives PAUSE_N low.
REQ-021 cpu_conflict  out  1  sticky flag: a CPU write was dropped during GRANT.

Function
REQ-022 The block SHALL be a four-state FSM: IDLE, DRAIN, GRANT, RELEASE.
REQ-023 IDLE: RAM mux selects CPU; ram_we = cpu_mreq & cpu_wr & in-window(cpu_ad); hs_access=1 -> DRAIN on the next edge.
REQ-024 cpu_pause SHALL be 1 in DRAIN and GRANT only, and registered (asserted the cycle after leaving IDLE).
REQ-025 DRAIN: the CPU retains the mux; an idle counter (width clog2(GUARD+1)) increments when cpu_mreq=0, clears to 0 when cpu_mreq=1, and saturates.
REQ-026 DRAIN -> GRANT when the counter equals GUARD; DRAIN -> IDLE if hs_access=0, which takes priority over the GRANT transition.
REQ-027 GRANT: hs_grant=1; mux selects the hiscore side; ram_ad = hs_ad - BASE (low AW bits); ram_we = hs_we & in-window(hs_ad); GRANT -> RELEASE when hs_access=0.
REQ-028 RELEASE: lasts exactly 1 cycle; hs_grant=0; cpu_pause=0; ram_we=0; -> IDLE.
REQ-029 Read latency: an hs_ad presented in cycle N SHALL appear on hs_do in cycle N+2 (BRAM + output register).
REQ-030 A read of an out-of-window hs_ad SHALL return 8'h00; an out-of-window write SHALL be dropped.
REQ-031 hs_do SHALL update only while the pipeline stage was granted; it holds its last value otherwise.
REQ-032 hs_we outside GRANT SHALL be ignored (no RAM write).
REQ-033 cpu_mreq & cpu_wr in GRANT SHALL perform no RAM write and SHALL set cpu_conflict.
REQ-034 In-window test: address >= BASE and address - BASE < 2^AW, computed in 17 bits with no wrap.

Reset
REQ-035 With reset_n=0 at an edge: state=IDLE, counter=0, hs_grant=0, cpu_pause=0, hs_do=8'h00, cpu_conflict=0, ram_we=0, read pipeline cleared.
REQ-036 Reset in any state, including mid-GRANT, SHALL return ownership to the CPU at the next edge with no RAM write on that edge.

Verification
REQ-037 Test 1: idle CPU; raise hs_access -> cpu_pause=1 one cycle later, hs_grant=1 after GUARD=4 idle cycles.
REQ-038 Test 2: cpu_mreq pulsing every third cycle during DRAIN -> no grant until 4 consecutive idle cycles occur.
REQ-039 Test 3: in GRANT, write 8'h5A at hs_ad=16'hC010, then read 16'hC010 -> ram_we with ram_ad=12'h010; hs_do=8'h5A two cycles after the read address.
REQ-040 Test 4: in GRANT, read 16'hB000 / write 16'hD000 -> hs_do=8'h00; ram_we stays 0.
REQ-041 Test 5: drop hs_access in GRANT -> RELEASE for 1 cycle, then IDLE; cpu_pause falls on entering RELEASE; a CPU write in GRANT sets cpu_conflict.
REQ-042 Test 6: assert reset_n=0 mid-GRANT -> next cycle all outputs at reset values and state=IDLE.

Source files
------------

// File: rtl/hiscore_ram_port.sv
// hiscore_ram_port
// -----------------------------------------------------------------------------
// Arbitrates the Z80 work-RAM port between the CPU and the hiscore engine.
// The CPU owns the RAM by default. When the hiscore engine raises hs_access,
// the core is stalled (cpu_pause) and the port waits for GUARD consecutive
// CPU-idle cycles before handing the RAM over (hs_grant). When hs_access
// drops, one RELEASE cycle separates the hiscore engine from the CPU again.
//
// Handshake: hs_access is a level request and hs_grant is the acknowledge.
// While hs_grant=1 the hiscore engine may present one address per cycle on
// hs_ad; read data for that address appears on hs_do two cycles later, and
// hs_we writes hs_di in the same cycle. Nothing on the hiscore side has any
// effect while hs_grant=0.
//
// Ports
//   clk48M        sole clock (rising edge)
//   reset_n       synchronous active-low reset
//   cpu_ad/do     Z80 address / write data
//   cpu_mreq/wr   Z80 memory cycle / write strobe
//   hs_access     hiscore ownership request (level)
//   hs_ad/di/we   hiscore address / write data / write strobe
//   ram_rd        work-RAM read data (1-cycle BRAM latency)
//   ram_ad/wd/we  work-RAM address / write data / write enable
//   hs_do         registered read data to the hiscore engine
//   hs_grant      hiscore engine owns the RAM
//   cpu_pause     stall request to the core
//   cpu_conflict  sticky: a CPU write was dropped while granted
//   state_dbg     current FSM state (0 IDLE, 1 DRAIN, 2 GRANT, 3 RELEASE)
// -----------------------------------------------------------------------------
module hiscore_ram_port #(
  parameter logic [15:0] BASE  = 16'hC000,
  parameter int          AW    = 12,
  parameter int          GUARD = 4          // must be >= 1
) (
  input  logic          clk48M,
  input  logic          reset_n,
  input  logic [15:0]   cpu_ad,
  input  logic [7:0]    cpu_do,
  input  logic          cpu_mreq,
  input  logic          cpu_wr,
  input  logic          hs_access,
  input  logic [15:0]   hs_ad,
  input  logic [7:0]    hs_di,
  input  logic          hs_we,
  input  logic [7:0]    ram_rd,
  output logic [AW-1:0] ram_ad,
  output logic [7:0]    ram_wd,
  output logic          ram_we,
  output logic [7:0]    hs_do,
  output logic          hs_grant,
  output logic          cpu_pause,
  output logic          cpu_conflict,
  output logic [1:0]    state_dbg
);

  localparam int            CW      = $clog2(GUARD + 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] idle_cnt;

  // Read pipeline: a granted address in cycle N is read by the BRAM at the
  // end of N; the stage below registers ram_rd into hs_do at the end of N+1.
  logic rd_valid;
  logic rd_inwin;

  // Offsets are taken in 17 bits so an address below BASE borrows into bit 16
  // instead of wrapping; in-window means every bit above the RAM index is 0.
  logic [16:0] cpu_off;
  logic [16:0] hs_off;
  logic        cpu_in;
  logic        hs_in;

  assign cpu_off = {1'b0, cpu_ad} - {1'b0, BASE};
  assign hs_off  = {1'b0, hs_ad}  - {1'b0, BASE};
  assign cpu_in  = (cpu_off[16:AW] == '0);
  assign hs_in   = (hs_off[16:AW]  == '0);

  assign state_dbg = state;

  // RAM mux. The CPU keeps the port in IDLE and DRAIN, the hiscore side has
  // it only in GRANT, and RELEASE writes nothing. Reset blocks any write on
  // the edge where it is sampled.
  always_comb begin
    ram_ad = cpu_off[AW-1:0];
    ram_wd = cpu_do;
    ram_we = 1'b0;
    case (state)
      S_IDLE, S_DRAIN: ram_we = cpu_mreq & cpu_wr & cpu_in;
      S_GRANT: begin
        ram_ad = hs_off[AW-1:0];
        ram_wd = hs_di;
        ram_we = hs_we & hs_in;
      end
      default: ram_we = 1'b0;
    endcase
    if (!reset_n) ram_we = 1'b0;
  end

  always_ff @(posedge clk48M) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idle_cnt     <= '0;
      hs_grant     <= 1'b0;
      cpu_pause    <= 1'b0;
      cpu_conflict <= 1'b0;
      rd_valid     <= 1'b0;
      rd_inwin     <= 1'b0;
      hs_do        <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          idle_cnt <= '0;
          if (hs_access) begin
            state     <= S_DRAIN;
            cpu_pause <= 1'b1;
          end
        end
        S_DRAIN: begin
          // A dropped request wins over a grant that is due this cycle.
          if (!hs_access) begin
            state     <= S_IDLE;
            cpu_pause <= 1'b0;
            idle_cnt  <= '0;
          end else if (idle_cnt == GUARD_C) begin
            state    <= S_GRANT;
            hs_grant <= 1'b1;
            idle_cnt <= '0;
          end else if (cpu_mreq) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        S_GRANT: begin
          if (cpu_mreq && cpu_wr) cpu_conflict <= 1'b1;
          if (!hs_access) begin
            state     <= S_RELEASE;
            hs_grant  <= 1'b0;
            cpu_pause <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      rd_valid <= (state == S_GRANT);
      rd_inwin <= hs_in;
      if (rd_valid) hs_do <= rd_inwin ? ram_rd : 8'h00;
    end
  end

endmodule
